// File: rtl/fir_stream_if.sv
// Streaming sample and coefficient-load bus for the parametrised FIR filter.
// The master drives samples and coefficient writes; the slave (the filter) returns filtered samples.
interface fir_stream_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int NTAPS  = 9
) ();
    localparam int ADDR_W = $clog2(NTAPS);

    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     coef_wr;
    logic [ADDR_W-1:0]        coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     coef_commit;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_sat;

    modport master (
        output in_valid, in_data, coef_wr, coef_addr, coef_data, coef_commit,
        input  out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, coef_wr, coef_addr, coef_data, coef_commit,
        output out_valid, out_data, out_sat
    );
endinterface

// File: rtl/fir_stream_param.sv
// Sample-enabled FIR: registered products, pipelined adder tree, round-half-up and saturation.
// Coefficients live in a shadow bank that is copied whole into the active bank on commit.
module fir_stream_param #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int NTAPS     = 9,
    parameter int OUT_SHIFT = 14
) (
    input logic         clk,
    input logic         rst_n,
    fir_stream_if.slave bus
);
    localparam int ADDR_W = $clog2(NTAPS);
    localparam int LVLS   = $clog2(NTAPS);
    localparam int LAT    = LVLS + 2;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = PROD_W + LVLS;
    localparam int RND_W  = SUM_W + 1;

    localparam logic signed [COEF_W-1:0] UNITY   = COEF_W'(1) << OUT_SHIFT;
    localparam logic signed [RND_W-1:0]  RND_C   = RND_W'(1) << (OUT_SHIFT - 1);
    localparam logic signed [RND_W-1:0]  SAT_MAX = {{(RND_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [RND_W-1:0]  SAT_MIN = {{(RND_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Tree nodes are packed level by level into one flat array: level 0 holds the products.
    function automatic int level_count(input int lvl);
        int n = NTAPS;
        for (int k = 0; k < lvl; k++) n = (n + 1) / 2;
        return n;
    endfunction

    function automatic int level_base(input int lvl);
        int b = 0;
        for (int k = 0; k < lvl; k++) b += level_count(k);
        return b;
    endfunction

    localparam int NODES = level_base(LVLS + 1);
    localparam int ROOT  = level_base(LVLS);

    logic signed [COEF_W-1:0] shadow      [NTAPS];
    logic signed [COEF_W-1:0] shadow_next [NTAPS];
    logic signed [COEF_W-1:0] active      [NTAPS];
    logic signed [DATA_W-1:0] dly         [NTAPS];
    logic signed [SUM_W-1:0]  node        [NODES];
    logic [LAT-1:0]           vld_sr;
    logic signed [RND_W-1:0]  rounded;
    logic signed [RND_W-1:0]  scaled;

    // Same-cycle write is folded in here so a simultaneous commit picks it up.
    always_comb begin
        for (int i = 0; i < NTAPS; i++) begin
            shadow_next[i] = shadow[i];
            if (bus.coef_wr && bus.coef_addr == ADDR_W'(i)) shadow_next[i] = bus.coef_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                shadow[i] <= (i == 0) ? UNITY : '0;
                active[i] <= (i == 0) ? UNITY : '0;
            end
        end else begin
            for (int i = 0; i < NTAPS; i++) begin
                shadow[i] <= shadow_next[i];
                if (bus.coef_commit) active[i] <= shadow_next[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) dly[i] <= '0;
        end else if (bus.in_valid) begin
            dly[0] <= bus.in_data;
            for (int i = 1; i < NTAPS; i++) dly[i] <= dly[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) vld_sr <= '0;
        else        vld_sr <= {vld_sr[LAT-2:0], bus.in_valid};
    end

    // Products and every tree level advance each cycle; validity rides in vld_sr alongside.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < NODES; n++) node[n] <= '0;
        end else begin
            for (int i = 0; i < NTAPS; i++)
                node[i] <= SUM_W'(PROD_W'(dly[i]) * PROD_W'(active[i]));
            for (int lv = 1; lv <= LVLS; lv++) begin
                for (int j = 0; j < level_count(lv); j++) begin
                    if (2 * j + 1 < level_count(lv - 1))
                        node[level_base(lv) + j] <= node[level_base(lv - 1) + 2 * j]
                                                  + node[level_base(lv - 1) + 2 * j + 1];
                    else
                        node[level_base(lv) + j] <= node[level_base(lv - 1) + 2 * j];
                end
            end
        end
    end

    assign rounded = RND_W'(node[ROOT]) + RND_C;
    assign scaled  = rounded >>> OUT_SHIFT;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sat   <= 1'b0;
        end else begin
            bus.out_valid <= vld_sr[LAT-1];
            if (scaled > SAT_MAX) begin
                bus.out_data <= OUT_MAX;
                bus.out_sat  <= 1'b1;
            end else if (scaled < SAT_MIN) begin
                bus.out_data <= OUT_MIN;
                bus.out_sat  <= 1'b1;
            end else begin
                bus.out_data <= scaled[DATA_W-1:0];
                bus.out_sat  <= 1'b0;
            end
        end
    end
endmodule
